// File: rtl/palindrome_stream_tx_if.sv
// Control and nibble-stream bundle for the palindrome stimulus transmitter.
// The master side is the transmitter; the slave side is the VIO/consumer.
interface palindrome_stream_tx_if;
   logic        start;
   logic [63:0] seq_in;
   logic [3:0]  len_in;
   logic        mirror_in;
   logic        abort;
   logic [3:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_first;
   logic        tx_last;
   logic [3:0]  tx_index;
   logic        busy;
   logic        done;

   modport master (
      input  start, seq_in, len_in, mirror_in, abort, tx_ready,
      output tx_data, tx_valid, tx_first, tx_last, tx_index, busy, done
   );

   modport slave (
      output start, seq_in, len_in, mirror_in, abort, tx_ready,
      input  tx_data, tx_valid, tx_first, tx_last, tx_index, busy, done
   );
endinterface

// File: rtl/palindrome_stream_tx.sv
// Captures a 64-bit nibble sequence and streams it MSB-nibble-first over
// valid/ready, optionally mirroring the first half so the stream is a palindrome.
module palindrome_stream_tx (
   input logic                    clk,
   input logic                    reset,
   palindrome_stream_tx_if.master bus
);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] seq_q, seq_d;
   logic [3:0]  last_q, last_d;   // N-1; len 0 wraps to 15, i.e. N=16
   logic [3:0]  idx_q, idx_d;
   logic        mirror_q, mirror_d;

   logic        send;
   logic        xfer;
   logic [4:0]  half;
   logic [3:0]  src;
   logic [5:0]  msb;

   assign send = (state_q == SEND);
   assign xfer = send & bus.tx_ready;

   // ceil(N/2) = (N+1)/2 = (last+2)/2; positions at or beyond it reflect.
   assign half = ({1'b0, last_q} + 5'd2) >> 1;
   assign src  = (mirror_q && ({1'b0, idx_q} >= half)) ? (last_q - idx_q) : idx_q;
   assign msb  = 6'd63 - {src, 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         seq_q    <= '0;
         last_q   <= '0;
         idx_q    <= '0;
         mirror_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         mirror_q <= mirror_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      last_d   = last_q;
      idx_d    = idx_q;
      mirror_d = mirror_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               seq_d    = bus.seq_in;
               last_d   = bus.len_in - 4'd1;
               mirror_d = bus.mirror_in;
               idx_d    = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (idx_q == last_q) state_d = DONE;
               else                 idx_d   = idx_q + 4'd1;
            end
            // Abort wins over DONE: a coinciding transfer still happens, no done pulse.
            if (bus.abort) state_d = IDLE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_valid = send;
   assign bus.tx_data  = send ? seq_q[msb -: 4] : 4'd0;
   assign bus.tx_first = send & (idx_q == 4'd0);
   assign bus.tx_last  = send & (idx_q == last_q);
   assign bus.tx_index = idx_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
endmodule
